// File: rtl/pll_pkg.sv
// rtl/pll_pkg.sv - shared types and helpers for the PLL configuration sequencer
package pll_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RESET,
    WAIT_LOCK,
    LOCKED,
    FAIL
  } pll_cfg_state_e;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_BAD_CFG   = 2'd1,
    ERR_TIMEOUT   = 2'd2,
    ERR_LOST_LOCK = 2'd3
  } pll_cfg_err_e;

  // Bits needed to hold the values 0..n-1, never less than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// rtl/pll_lock_sync.sv - two-flop synchronizer for an asynchronous level, resets to 0
module pll_lock_sync (
  input  logic clk,
  input  logic arst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops give the first stage a full cycle to resolve.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_cfg_ctrl.sv
// rtl/pll_cfg_ctrl.sv - PLL divider load / lock sequencer; PLL_CFG_CTRL_LOL_EN enables the loss-of-lock monitor
module pll_cfg_ctrl
  import pll_pkg::*;
#(
  parameter int REF_DEV_WIDTH = 4,
  parameter int FB_DEV_WIDTH  = 8,
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_STABLE   = 8,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int MAX_RETRY     = 3
) (
  input  logic                              clk_i,
  input  logic                              arst_i,
  input  logic [REF_DEV_WIDTH-1:0]          req_refdiv_i,
  input  logic [FB_DEV_WIDTH-1:0]           req_fbdiv_i,
  input  logic                              req_valid_i,
  output logic                              req_ready_o,
  output logic                              pll_arst_no,
  output logic [REF_DEV_WIDTH-1:0]          pll_refdiv_o,
  output logic [FB_DEV_WIDTH-1:0]           pll_fbdiv_o,
  input  logic                              pll_locked_i,
  output logic                              busy_o,
  output logic                              locked_o,
  output logic [1:0]                        err_code_o,
  output logic [cnt_w(MAX_RETRY+1)-1:0]     retry_cnt_o
);

  localparam int RST_W   = cnt_w(RST_CYCLES);
  localparam int TO_W    = cnt_w(LOCK_TIMEOUT + 1);
  localparam int ST_W    = cnt_w(LOCK_STABLE + 1);
  localparam int RETRY_W = cnt_w(MAX_RETRY + 1);

  localparam logic [RST_W-1:0]   RST_LAST  = RST_W'(RST_CYCLES - 1);
  localparam logic [TO_W-1:0]    TO_MAX    = TO_W'(LOCK_TIMEOUT);
  localparam logic [ST_W-1:0]    ST_MAX    = ST_W'(LOCK_STABLE);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  pll_cfg_state_e           state_q, state_d;
  pll_cfg_err_e             err_q, err_d;
  logic [REF_DEV_WIDTH-1:0] ref_q, ref_d;
  logic [FB_DEV_WIDTH-1:0]  fb_q, fb_d;
  logic [RETRY_W-1:0]       retry_q, retry_d;
  logic [RST_W-1:0]         rst_cnt_q, rst_cnt_d;
  logic [TO_W-1:0]          to_cnt_q, to_cnt_d;
  logic [ST_W-1:0]          stable_q, stable_d;
  logic [TO_W-1:0]          to_inc;
  logic [ST_W-1:0]          stable_inc;
  logic                     lock_sync;
  logic                     accept;
`ifdef PLL_CFG_CTRL_LOL_EN
  // Remembers that the previous synchronized lock sample in LOCKED was low.
  logic                     lol_q, lol_d;
`endif

  pll_lock_sync u_lock_sync (
    .clk  (clk_i),
    .arst (arst_i),
    .d    (pll_locked_i),
    .q    (lock_sync)
  );

  // Status outputs decode straight from state so reset takes them to idle values without a clock.
  always_comb begin
    req_ready_o = (state_q == IDLE) || (state_q == LOCKED) || (state_q == FAIL);
    pll_arst_no = (state_q == WAIT_LOCK) || (state_q == LOCKED);
    busy_o      = (state_q == RESET) || (state_q == WAIT_LOCK);
    locked_o    = (state_q == LOCKED);
  end

  assign accept       = req_valid_i && req_ready_o;
  assign pll_refdiv_o = ref_q;
  assign pll_fbdiv_o  = fb_q;
  assign err_code_o   = err_q;
  assign retry_cnt_o  = retry_q;

  // Saturating increments so no counter can wrap back into a valid-looking value.
  assign to_inc     = (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + TO_W'(1);
  assign stable_inc = (stable_q == ST_MAX) ? stable_q : stable_q + ST_W'(1);

  // State register and all sequencer bookkeeping.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q   <= IDLE;
      err_q     <= ERR_NONE;
      ref_q     <= '0;
      fb_q      <= '0;
      retry_q   <= '0;
      rst_cnt_q <= '0;
      to_cnt_q  <= '0;
      stable_q  <= '0;
`ifdef PLL_CFG_CTRL_LOL_EN
      lol_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      ref_q     <= ref_d;
      fb_q      <= fb_d;
      retry_q   <= retry_d;
      rst_cnt_q <= rst_cnt_d;
      to_cnt_q  <= to_cnt_d;
      stable_q  <= stable_d;
`ifdef PLL_CFG_CTRL_LOL_EN
      lol_q     <= lol_d;
`endif
    end
  end

  // Next-state logic; a new request overrides whatever the current state would do.
  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    ref_d     = ref_q;
    fb_d      = fb_q;
    retry_d   = retry_q;
    rst_cnt_d = rst_cnt_q;
    to_cnt_d  = to_cnt_q;
    stable_d  = stable_q;
`ifdef PLL_CFG_CTRL_LOL_EN
    lol_d     = lol_q;
`endif

    case (state_q)
      RESET: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d  = WAIT_LOCK;
          to_cnt_d = '0;
          stable_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + RST_W'(1);
        end
      end
      WAIT_LOCK: begin
        to_cnt_d = to_inc;
        stable_d = lock_sync ? stable_inc : '0;
        // Lock is tested first so a lock on the timeout cycle still counts.
        if (lock_sync && (stable_inc == ST_MAX)) begin
          state_d = LOCKED;
`ifdef PLL_CFG_CTRL_LOL_EN
          lol_d   = 1'b0;
`endif
        end else if (to_inc == TO_MAX) begin
          if (retry_q < RETRY_MAX) begin
            retry_d   = retry_q + RETRY_W'(1);
            rst_cnt_d = '0;
            state_d   = RESET;
          end else begin
            err_d   = ERR_TIMEOUT;
            state_d = FAIL;
          end
        end
      end
      LOCKED: begin
`ifdef PLL_CFG_CTRL_LOL_EN
        lol_d = !lock_sync;
        if (!lock_sync && lol_q) begin
          err_d     = ERR_LOST_LOCK;
          retry_d   = '0;
          rst_cnt_d = '0;
          lol_d     = 1'b0;
          state_d   = RESET;
        end
`endif
      end
      default: ;
    endcase

    if (accept) begin
      retry_d   = '0;
      rst_cnt_d = '0;
`ifdef PLL_CFG_CTRL_LOL_EN
      lol_d     = 1'b0;
`endif
      if ((req_refdiv_i == '0) || (req_fbdiv_i == '0)) begin
        // Illegal config: keep the PLL in reset on its previous dividers.
        err_d   = ERR_BAD_CFG;
        state_d = FAIL;
      end else begin
        ref_d   = req_refdiv_i;
        fb_d    = req_fbdiv_i;
        err_d   = ERR_NONE;
        state_d = RESET;
      end
    end
  end

endmodule
